// File: rtl/microwave_ctrl_if.sv
// Front-panel bundle for the microwave controller.
//   master: panel side (drives keys/buttons/door, observes display and magnetron)
//   slave : controller side (microwave_ctrl)
// Signals:
//   keypad[9:0]    one-hot digit keys, bit n = digit n
//   startn/stopn/clearn  active-low buttons
//   door_closed    1 = door closed
//   mins_seg, sec_tens_seg, sec_ones_seg  7-seg patterns (bit0 = a .. bit6 = g)
//   mag_on         magnetron enable
interface microwave_ctrl_if;
    logic [9:0] keypad;
    logic       startn;
    logic       stopn;
    logic       clearn;
    logic       door_closed;
    logic [6:0] sec_ones_seg;
    logic [6:0] sec_tens_seg;
    logic [6:0] mins_seg;
    logic       mag_on;

    modport master (
        output keypad, startn, stopn, clearn, door_closed,
        input  sec_ones_seg, sec_tens_seg, mins_seg, mag_on
    );

    modport slave (
        input  keypad, startn, stopn, clearn, door_closed,
        output sec_ones_seg, sec_tens_seg, mins_seg, mag_on
    );
endinterface

// File: rtl/microwave_ctrl.sv
// Microwave oven timer/controller: keypad entry of an M:SS cook time, start/stop/clear
// buttons, door interlock, once-per-second countdown while cooking.
// Ports:
//   clock  system clock, rising edge
//   reset  asynchronous, active-high
//   panel  microwave_ctrl_if.slave (keys, buttons, door in; 7-seg digits, mag_on out)
// Parameter:
//   TICKS_PER_SEC  clock cycles per countdown second
// Build option:
//   SEG_ACTIVE_LOW_EN  when defined, segment outputs are inverted (0 = lit)
module microwave_ctrl #(
    parameter int unsigned TICKS_PER_SEC = 100
) (
    input logic              clock,
    input logic              reset,
    microwave_ctrl_if.slave  panel
);

    localparam int unsigned TickW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [TickW-1:0] TickLast = TickW'(TICKS_PER_SEC - 1);

    typedef enum logic [1:0] {StIdle, StCook, StPaused} state_e;

    state_e           state_q, state_d;
    logic [3:0]       mins_q, mins_d, tens_q, tens_d, ones_q, ones_d;
    logic [TickW-1:0] tick_q, tick_d;
    logic             mag_on_q, mag_on_d;

    // Input sample stage plus previous sample for press-edge detection.
    logic [9:0] key_q, key_prev_q;
    logic       startn_q, startn_prev_q, stopn_q, clearn_q, door_q;

    logic       start_evt, key_evt, key_onehot, time_zero, dec_zero;
    logic [3:0] key_digit, dec_mins, dec_tens, dec_ones;

    always_comb begin
        key_digit = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (key_q[i]) key_digit = 4'(i);
        end
    end

    assign key_onehot = (key_q != 10'd0) && ((key_q & (key_q - 10'd1)) == 10'd0);
    assign key_evt    = (key_prev_q == 10'd0) && key_onehot;
    assign start_evt  = startn_prev_q && !startn_q;
    assign time_zero  = (mins_q == 4'd0) && (tens_q == 4'd0) && (ones_q == 4'd0);

    // One-second decrement with borrow; seconds above 59 simply count down as entered.
    always_comb begin
        dec_mins = mins_q;
        dec_tens = tens_q;
        dec_ones = ones_q;
        if (ones_q != 4'd0) begin
            dec_ones = ones_q - 4'd1;
        end else if (tens_q != 4'd0) begin
            dec_tens = tens_q - 4'd1;
            dec_ones = 4'd9;
        end else begin
            dec_mins = mins_q - 4'd1;
            dec_tens = 4'd5;
            dec_ones = 4'd9;
        end
    end

    assign dec_zero = (dec_mins == 4'd0) && (dec_tens == 4'd0) && (dec_ones == 4'd0);

    always_comb begin
        state_d = state_q;
        mins_d  = mins_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        tick_d  = tick_q;
        if (!clearn_q) begin
            state_d = StIdle;
            mins_d  = 4'd0;
            tens_d  = 4'd0;
            ones_d  = 4'd0;
            tick_d  = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_evt && door_q && !time_zero) begin
                        state_d = StCook;
                        tick_d  = '0;
                    end else if (key_evt) begin
                        mins_d = tens_q;
                        tens_d = ones_q;
                        ones_d = key_digit;
                    end
                end
                StCook: begin
                    if (!door_q || !stopn_q) begin
                        state_d = StPaused;
                    end else if (tick_q == TickLast) begin
                        tick_d = '0;
                        mins_d = dec_mins;
                        tens_d = dec_tens;
                        ones_d = dec_ones;
                        if (dec_zero) state_d = StIdle;
                    end else begin
                        tick_d = tick_q + TickW'(1);
                    end
                end
                StPaused: begin
                    if (start_evt && door_q) begin
                        state_d = StCook;
                        tick_d  = '0;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
        mag_on_d = (state_d == StCook);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            mins_q        <= 4'd0;
            tens_q        <= 4'd0;
            ones_q        <= 4'd0;
            tick_q        <= '0;
            mag_on_q      <= 1'b0;
            key_q         <= 10'd0;
            key_prev_q    <= 10'd0;
            startn_q      <= 1'b1;
            startn_prev_q <= 1'b1;
            stopn_q       <= 1'b1;
            clearn_q      <= 1'b1;
            door_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            mins_q        <= mins_d;
            tens_q        <= tens_d;
            ones_q        <= ones_d;
            tick_q        <= tick_d;
            mag_on_q      <= mag_on_d;
            key_q         <= panel.keypad;
            key_prev_q    <= key_q;
            startn_q      <= panel.startn;
            startn_prev_q <= startn_q;
            stopn_q       <= panel.stopn;
            clearn_q      <= panel.clearn;
            door_q        <= panel.door_closed;
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b0111111;
            4'd1:    seg7 = 7'b0000110;
            4'd2:    seg7 = 7'b1011011;
            4'd3:    seg7 = 7'b1001111;
            4'd4:    seg7 = 7'b1100110;
            4'd5:    seg7 = 7'b1101101;
            4'd6:    seg7 = 7'b1111101;
            4'd7:    seg7 = 7'b0000111;
            4'd8:    seg7 = 7'b1111111;
            4'd9:    seg7 = 7'b1101111;
            default: seg7 = 7'b0000000;
        endcase
    endfunction

`ifdef SEG_ACTIVE_LOW_EN
    assign panel.mins_seg     = ~seg7(mins_q);
    assign panel.sec_tens_seg = ~seg7(tens_q);
    assign panel.sec_ones_seg = ~seg7(ones_q);
`else
    assign panel.mins_seg     = seg7(mins_q);
    assign panel.sec_tens_seg = seg7(tens_q);
    assign panel.sec_ones_seg = seg7(ones_q);
`endif

    assign panel.mag_on = mag_on_q;

endmodule

// File: tb/tb_microwave_ctrl.sv
// Self-checking bench for microwave_ctrl: directed scenarios followed by random
// panel operations, all compared against a time-in-seconds reference model.
module tb_microwave_ctrl;

    localparam int unsigned T = 20;

    logic clock = 1'b0;
    logic reset;

    microwave_ctrl_if panel ();

    microwave_ctrl #(.TICKS_PER_SEC(T)) dut (
        .clock (clock),
        .reset (reset),
        .panel (panel)
    );

    always #5 clock = ~clock;

    // Reference model: minutes digit, seconds value as entered (0..99), state 0/1/2.
    int m_min, m_sec, m_state;
    bit m_door;
    int n_cmp, n_bad;

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    function automatic logic [6:0] exp_seg(input int d);
`ifdef SEG_ACTIVE_LOW_EN
        return ~seg_tab[d];
`else
        return seg_tab[d];
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (model %0d:%0d st=%0d)",
                     tag, got, exp, m_min, m_sec, m_state);
        end
    endtask

    task automatic check_display(input string tag);
        check({tag, ".min"}, 32'(panel.mins_seg), 32'(exp_seg(m_min)));
        check({tag, ".tens"}, 32'(panel.sec_tens_seg), 32'(exp_seg(m_sec / 10)));
        check({tag, ".ones"}, 32'(panel.sec_ones_seg), 32'(exp_seg(m_sec % 10)));
        check({tag, ".mag"}, 32'(panel.mag_on), 32'(m_state == 1));
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    function automatic void model_tick();
        if (m_state != 1) return;
        if (m_sec > 0) m_sec--;
        else begin
            m_min--;
            m_sec = 59;
        end
        if (m_min == 0 && m_sec == 0) m_state = 0;
    endfunction

    task automatic press_key(input logic [9:0] k, input int hold);
        int v;
        panel.keypad = k;
        cyc(hold);
        panel.keypad = '0;
        cyc(3);
        if (m_state == 0 && $countones(k) == 1) begin
            for (int i = 0; i < 10; i++) begin
                if (k[i]) v = ((m_min * 100 + m_sec) * 10 + i) % 1000;
            end
            m_min = v / 100;
            m_sec = v % 100;
        end
    endtask

    task automatic enter3(input int a, input int b, input int c);
        press_key(10'(1 << a), 3);
        press_key(10'(1 << b), 3);
        press_key(10'(1 << c), 3);
    endtask

    // Start press, then stay k seconds plus half a second so edges are never ambiguous.
    task automatic start_run(input int k);
        panel.startn = 1'b0;
        cyc(3);
        panel.startn = 1'b1;
        cyc(k * T + T / 2 - 3);
        if (m_door && ((m_state == 0 && (m_min != 0 || m_sec != 0)) || m_state == 2))
            m_state = 1;
        for (int i = 0; i < k; i++) model_tick();
    endtask

    task automatic finish_run();
        int r;
        if (m_state == 1) begin
            r = m_min * 60 + m_sec;
            cyc(r * T + T);
            for (int i = 0; i < r; i++) model_tick();
        end
    endtask

    task automatic pulse_stop();
        panel.stopn = 1'b0;
        cyc(3);
        panel.stopn = 1'b1;
        cyc(3);
        if (m_state == 1) m_state = 2;
    endtask

    task automatic pulse_clear();
        panel.clearn = 1'b0;
        cyc(3);
        panel.clearn = 1'b1;
        cyc(3);
        m_state = 0;
        m_min = 0;
        m_sec = 0;
    endtask

    task automatic set_door(input bit closed);
        panel.door_closed = closed;
        m_door = closed;
        cyc(3);
        if (!closed && m_state == 1) m_state = 2;
    endtask

    initial begin
        int op, e, k;
        n_cmp = 0;
        n_bad = 0;
        panel.keypad = '0;
        panel.startn = 1'b1;
        panel.stopn = 1'b1;
        panel.clearn = 1'b1;
        panel.door_closed = 1'b1;
        m_door = 1;
        m_min = 0;
        m_sec = 0;
        m_state = 0;
        reset = 1'b1;
        cyc(2);
        check_display("reset");
        reset = 1'b0;
        cyc(2);

        // Door open start, then full 3:59 countdown.
        set_door(0);
        enter3(3, 5, 9);
        start_run(1);
        check_display("door_open_start");
        set_door(1);
        start_run(1);
        check_display("cook_3_58");
        finish_run();
        check_display("cook_done");

        // Door open mid-cook.
        enter3(2, 4, 5);
        start_run(30);
        check_display("door_mid_run");
        set_door(0);
        check_display("door_paused");
        start_run(0);
        check_display("door_start_ign");
        set_door(1);
        start_run(1);
        check_display("door_resume");
        finish_run();
        check_display("door_done");

        // Stop mid-cook.
        enter3(2, 4, 5);
        start_run(30);
        pulse_stop();
        check_display("stop_held");
        start_run(0);
        finish_run();
        check_display("stop_done");

        // Clear mid-cook.
        enter3(2, 4, 5);
        start_run(30);
        pulse_clear();
        check_display("clear");
        start_run(1);
        check_display("start_zero_ign");

        // Borrow across the minute.
        enter3(1, 0, 0);
        start_run(1);
        check_display("borrow_0_59");
        pulse_clear();

        // Seconds above 59 count down as entered.
        press_key(10'(1 << 7), 3);
        press_key(10'(1 << 5), 3);
        start_run(2);
        check_display("sec_75");
        pulse_clear();

        // Held key and double key.
        press_key(10'(1 << 7), 12);
        check_display("held_key");
        press_key(10'b00000_10010, 3);
        check_display("double_key");

        // Asynchronous reset mid-cook.
        enter3(1, 2, 3);
        start_run(2);
        @(posedge clock);
        #2;
        reset = 1'b1;
        m_state = 0;
        m_min = 0;
        m_sec = 0;
        #1;
        check_display("async_reset");
        @(negedge clock);
        reset = 1'b0;
        cyc(2);

        // Random panel operations.
        for (int n = 0; n < 60; n++) begin
            op = $urandom_range(0, 5);
            case (op)
                0, 1: begin
                    if ($urandom_range(0, 9) == 0)
                        press_key(10'(3 << $urandom_range(0, 8)), 3);
                    else
                        press_key(10'(1 << $urandom_range(0, 9)), $urandom_range(2, 6));
                end
                2: begin
                    k = $urandom_range(0, 3);
                    start_run(k);
                    check_display("rnd_run");
                    e = $urandom_range(0, 3);
                    if (e == 3 && m_min * 60 + m_sec > 40) e = 0;
                    case (e)
                        0: pulse_stop();
                        1: set_door(0);
                        2: pulse_clear();
                        default: finish_run();
                    endcase
                end
                3: set_door($urandom_range(0, 2) != 0);
                4: pulse_clear();
                default: pulse_stop();
            endcase
            check_display("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/microwave_ctrl.md
Name: microwave_ctrl

Overview:
- Microwave oven timer/controller: one-hot decimal keypad entry of an M:SS cook time, start/stop/clear buttons and a door interlock.
- Counts the time down once per second while the magnetron is on.
- Drives three 7-segment digits: minutes, seconds-tens and seconds-ones.
- Top-level control block sitting between front-panel inputs and the display/magnetron driver.

Parameters:
TICKS_PER_SEC, 100, clock cycles per countdown second (100 = 100 Hz system clock)

Ports:
clock  input  1  system clock, rising-edge; one clock domain only
reset  input  1  asynchronous, active-high reset
keypad  input  10  one-hot digit keys; bit n = digit n
startn  input  1  start button, active-low
stopn  input  1  stop/pause button, active-low
clearn  input  1  clear button, active-low
door_closed  input  1  1 = door closed
sec_ones_seg  output  7  7-seg pattern, seconds ones digit
sec_tens_seg  output  7  7-seg pattern, seconds tens digit
mins_seg  output  7  7-seg pattern, minutes digit
mag_on  output  1  magnetron enable; 1 only in COOK

Behaviour:
- Reset (async): state IDLE, mins = tens = ones = 0, tick counter = 0, mag_on = 0, all segment outputs show "0".
- Segment encoding: bit0 = a … bit6 = g, 1 = segment lit. Digit patterns 0-9 are standard; "0" = 7'b0111111.
- Button and keypad inputs are registered; actions fire on press edges:
  - startn: 1→0
  - keypad: all-zero → non-zero
  - Holding a key or button produces exactly one event.
- Keypad event:
  - Accepted only in IDLE, and only if exactly one bit is set; otherwise ignored.
  - Shift-in: mins <= tens, tens <= ones, ones <= digit. The old mins digit is discarded.
  - Example: keys 3, 5, 9 give 3:59.
- States: IDLE, COOK, PAUSED.
- IDLE → COOK on a start event when door_closed = 1 and time ≠ 0:00. Otherwise the start is ignored and the state stays IDLE.
- PAUSED → COOK on a start event when door_closed = 1. Otherwise stays PAUSED.
- On entry to COOK, the tick counter clears to 0.
- In COOK:
  - Tick counter increments every cycle.
  - At TICKS_PER_SEC-1 it wraps and the time decrements one second.
- Decrement rules:
  - If ones ≠ 0: ones - 1.
  - Else if tens ≠ 0: tens - 1, ones = 9.
  - Else (mins ≠ 0): mins - 1, tens = 5, ones = 9.
  - Seconds values ≥ 60 (e.g. 0:75) count down as entered.
- Reaching 0:00 in COOK → IDLE with mag_on = 0 on that same clock edge.
- COOK → PAUSED when door_closed = 0 or stopn = 0 (level). The time is held.
- clearn = 0 (level), any state → IDLE with time 0:00.
- Priority for simultaneous events: reset > clear > door-open/stop > decrement > start > keypad.
- mag_on is registered: 1 if and only if state = COOK.
- Segment outputs are combinational decode of the digit registers.
- In PAUSED, the keypad is ignored; stop has no further effect.

Optional Feature:
SEG_ACTIVE_LOW_EN
- Defined: all three segment outputs are bitwise inverted (0 = lit), for common-anode displays. Reset shows "0" as 7'b1000000.
- Undefined: active-high encoding as specified above.

Test Plan:
- Door-open start: door_closed = 0, keys 3, 5, 9, then start → display 3:59, mag_on stays 0. Close the door, start → mag_on = 1. Display reads 3:58 after TICKS_PER_SEC cycles, counts to 0:00 after 239 s, then mag_on = 0 and state IDLE.
- Door open mid-cook: enter 2:45, start, open the door after 30 s → mag_on = 0, display frozen at 2:15. A start with the door open is ignored. Close the door, start → resumes from 2:15 and runs to 0:00.
- Stop mid-cook: enter 2:45, start, stopn = 0 after 30 s → mag_on = 0, held at 2:15. Release stopn, start → resumes from 2:15 and finishes.
- Clear mid-cook: enter 2:45, start, clearn = 0 after 30 s → display 0:00, mag_on = 0. A later start is ignored.
- Borrow and edge cases:
  - 1:00 becomes 0:59 after 1 s.
  - Start at 0:00 is ignored.
  - A held key registers once.
  - Two keys pressed at once are ignored.
- Reset asserted mid-cook → outputs are immediately 0:00 and mag_on = 0, asynchronously without waiting for a clock edge.
